// File: rtl/ram_4kx4.sv
// 4096 x 4 single-port SRAM on a shared tri-state data bus.
// Writes commit on the rising clock edge; reads drive the bus combinationally.
`timescale 1ns/1ps

module ram_4kx4 #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data_bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Reset gates the read driver directly so the bus is released the moment rst_n falls.
  logic rd_sel;
  logic wr_sel;
  assign rd_sel = rst_n & enable & ~write_enable;
  assign wr_sel = enable & write_enable;

  // All words, flattened so the read mux can index them by address.
  logic [DEPTH*DATA_WIDTH-1:0] mem_flat;

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;

    // NOTE: every variable assigned in always_comb gets a default first, or a latch is inferred.
    always_comb begin
      word_d = word_q;
      if (wr_sel && (addr == ADDR_WIDTH'(g))) begin
        word_d = data_bus;
      end
    end

    // NOTE: clearing the whole memory on reset means each word is a flop with its own
    // reset branch; a reset cannot be applied to a RAM macro, and a per-word block
    // avoids a non-blocking assignment to an array inside a loop.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign mem_flat[g*DATA_WIDTH +: DATA_WIDTH] = word_q;
  end

  assign data_bus = rd_sel ? mem_flat[DATA_WIDTH*int'(addr) +: DATA_WIDTH]
                           : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_4kx4.sv
// Self-checking bench for ram_4kx4: directed scenarios plus randomized traffic
// compared against an array model of the memory.
`timescale 1ns/1ps

module tb_ram_4kx4;

  localparam int AW    = 12;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          write_enable;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data_bus;

  // Bench-side bus driver: owns the bus whenever the RAM must be released.
  logic          drv_en;
  logic [DW-1:0] drv_val;
  assign data_bus = drv_en ? drv_val : {DW{1'bz}};

  ram_4kx4 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .write_enable (write_enable),
    .addr         (addr),
    .data_bus     (data_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: plain array, cleared on reset, updated on writes.
  logic [DW-1:0] model_mem [DEPTH];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one bus cycle. Inputs change at the falling edge; the bus is sampled 1ns later.
  // When the RAM is reading, the bench releases the bus and expects the model word;
  // otherwise the bench drives d and expects to see d unchanged (RAM released).
  task automatic step(input string tag, input logic rst, input logic en, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic reading;
    @(negedge clk);
    rst_n        = rst;
    enable       = en;
    write_enable = we;
    addr         = a;
    reading      = rst && en && !we;
    drv_en       = !reading;
    drv_val      = d;
    #1;
    if (reading) check({tag, "_read"}, data_bus, model_mem[a]);
    else         check({tag, "_release"}, data_bus, d);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (en && we) begin
      model_mem[a] = d;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    write_enable = 1'b0;
    addr         = '0;
    drv_en       = 1'b1;
    drv_val      = 4'h3;

    // Reset, then every probed address reads zero.
    step("reset",      1'b0, 1'b0, 1'b0, 12'd0,    4'h3);
    step("rst_rd0",    1'b1, 1'b1, 1'b0, 12'd0,    4'h0);
    step("rst_rd4095", 1'b1, 1'b1, 1'b0, 12'd4095, 4'h0);

    // Idle: bench owns the bus, memory untouched.
    step("idle",       1'b1, 1'b0, 1'b0, 12'd0,    4'h1);
    step("idle_rd0",   1'b1, 1'b1, 1'b0, 12'd0,    4'h0);

    // Write then immediate read; neighbour unaffected.
    step("wr2",        1'b1, 1'b1, 1'b1, 12'd2,    4'h2);
    step("rd2",        1'b1, 1'b1, 1'b0, 12'd2,    4'h0);
    check("rd2_value", data_bus, 4'h2);
    step("rd3",        1'b1, 1'b1, 1'b0, 12'd3,    4'h0);

    // Idle over a non-zero word with complementary bench data exposes any contention.
    step("idle_c",     1'b1, 1'b0, 1'b0, 12'd2,    4'hD);
    step("wrmode_c",   1'b1, 1'b1, 1'b1, 12'd2,    4'hD);
    step("rd2_after",  1'b1, 1'b1, 1'b0, 12'd2,    4'h0);

    // Combinational read: address change inside one low phase, no clock edge.
    step("wr10",       1'b1, 1'b1, 1'b1, 12'd10,   4'hA);
    step("wr11",       1'b1, 1'b1, 1'b1, 12'd11,   4'h5);
    @(negedge clk);
    enable = 1'b1; write_enable = 1'b0; drv_en = 1'b0; addr = 12'd10;
    #1 check("comb_a10", data_bus, 4'hA);
    addr = 12'd11;
    #1 check("comb_a11", data_bus, 4'h5);
    addr = 12'd10;
    #1 check("comb_back", data_bus, 4'hA);

    // Reset priority and bus release during reset.
    step("wr7",        1'b1, 1'b1, 1'b1, 12'd7,    4'hA);
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b1; write_enable = 1'b0; addr = 12'd7;
    drv_en = 1'b1; drv_val = 4'h5;
    #1 check("rst_release", data_bus, 4'h5);
    write_enable = 1'b1; drv_val = 4'hF;
    #1 check("rst_wr_release", data_bus, 4'hF);
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    step("rd7_after_rst",  1'b1, 1'b1, 1'b0, 12'd7,  4'h0);
    check("rd7_zero", data_bus, 4'h0);
    step("rd10_after_rst", 1'b1, 1'b1, 1'b0, 12'd10, 4'h0);

    // Boundary addresses and aliasing.
    step("wr0",        1'b1, 1'b1, 1'b1, 12'd0,    4'h9);
    step("wr4095",     1'b1, 1'b1, 1'b1, 12'd4095, 4'h6);
    step("rd0",        1'b1, 1'b1, 1'b0, 12'd0,    4'h0);
    check("rd0_value", data_bus, 4'h9);
    step("rd4095",     1'b1, 1'b1, 1'b0, 12'd4095, 4'h0);
    check("rd4095_value", data_bus, 4'h6);
    step("rd2048",     1'b1, 1'b1, 1'b0, 12'd2048, 4'h0);

    // Randomized traffic against the model; addresses biased to collide often.
    for (int i = 0; i < 600; i++) begin
      logic          r_rst;
      logic          r_en;
      logic          r_we;
      logic [AW-1:0] r_a;
      logic [DW-1:0] r_d;
      int            sel;
      r_rst = ($urandom_range(0, 199) != 0);
      r_en  = ($urandom_range(0, 4) != 0);
      r_we  = $urandom_range(0, 1) == 1;
      sel   = $urandom_range(0, 9);
      if (sel < 6)       r_a = AW'($urandom_range(0, 15));
      else if (sel < 8)  r_a = AW'(DEPTH - 1 - $urandom_range(0, 3));
      else               r_a = AW'($urandom);
      r_d = DW'($urandom);
      step("rand", r_rst, r_en, r_we, r_a, r_d);
    end

    // Final sweep of the hot addresses against the model.
    for (int a = 0; a < 16; a++) begin
      step("sweep", 1'b1, 1'b1, 1'b0, AW'(a), 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
